// File: rtl/i2c_target_regs.sv
// I2C target answering a 7-bit address, backed by a 4-byte register bank that is
// also reachable from an Avalon-MM slave. SDA is driven open-drain, no clock stretching.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       rx_strobe
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t     state_q;
  logic [7:0] bank_q [4];
  logic [1:0] ptr_q;
  logic [6:0] shift_q;
  logic [7:0] tx_q;
  logic [3:0] cnt_q;
  logic       ack_hold_q;
  logic       rw_q;
  logic       sda_oe_q;
  logic       rx_strobe_q;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;

  logic       scl_cur, sda_cur;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_d;
  logic [1:0] ptr_inc_d;
  logic       last_bit_d;
  logic       av_we_d;

  // Two-flop synchronizers plus a history flop; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  always_comb begin
    scl_cur    = scl_sync_q[1];
    sda_cur    = sda_sync_q[1];
    scl_rise   = ~scl_prev_q & scl_cur;
    scl_fall   = scl_prev_q & ~scl_cur;
    start_det  = scl_prev_q & scl_cur & sda_prev_q & ~sda_cur;
    stop_det   = scl_prev_q & scl_cur & ~sda_prev_q & sda_cur;
    byte_d     = {shift_q, sda_cur};
    ptr_inc_d  = ptr_q + 2'd1;
    last_bit_d = (cnt_q == 4'd7);
    av_we_d    = chipselect & ~write_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < 4; i++) bank_q[i] <= '0;
      ptr_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      cnt_q       <= '0;
      ack_hold_q  <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_strobe_q <= 1'b0;
    end else begin
      rx_strobe_q <= 1'b0;
      if (start_det) begin
        state_q    <= ADDR;
        cnt_q      <= '0;
        sda_oe_q   <= 1'b0;
        ack_hold_q <= 1'b0;
      end else if (stop_det) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        sda_oe_q   <= 1'b0;
        ack_hold_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shift_q <= byte_d[6:0];
              cnt_q   <= cnt_q + 4'd1;
              if (last_bit_d) begin
                cnt_q <= '0;
                if (state_q == ADDR) begin
                  if (byte_d[7:1] == I2C_ADDR) begin
                    rw_q    <= byte_d[0];
                    state_q <= ADDR_ACK;
                  end else begin
                    state_q <= IDLE;
                  end
                end else if (state_q == PTR) begin
                  ptr_q   <= byte_d[1:0];
                  state_q <= PTR_ACK;
                end else begin
                  bank_q[ptr_q] <= byte_d;
                  rx_strobe_q   <= 1'b1;
                  ptr_q         <= ptr_inc_d;
                  state_q       <= WDATA_ACK;
                end
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_hold_q) begin
                sda_oe_q   <= 1'b1;
                ack_hold_q <= 1'b1;
              end else begin
                ack_hold_q <= 1'b0;
                sda_oe_q   <= 1'b0;
                // Read: the fall that ends the ACK also launches the first data bit.
                if (state_q == ADDR_ACK && rw_q) begin
                  tx_q     <= {bank_q[ptr_q][6:0], 1'b0};
                  sda_oe_q <= ~bank_q[ptr_q][7];
                  cnt_q    <= 4'd1;
                  state_q  <= RDATA;
                end else if (state_q == ADDR_ACK) begin
                  state_q <= PTR;
                end else begin
                  state_q <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                state_q  <= RDATA_ACK;
              end else begin
                sda_oe_q <= ~tx_q[7];
                tx_q     <= {tx_q[6:0], 1'b0};
                cnt_q    <= cnt_q + 4'd1;
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_cur) begin
                ptr_q   <= ptr_inc_d;
                tx_q    <= bank_q[ptr_inc_d];
                state_q <= RDATA;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // Placed last so an Avalon write overrides a same-cycle I2C write.
      if (av_we_d) bank_q[address] <= writedata;
    end
  end

  always_comb begin
    readdata  = chipselect ? bank_q[address] : '0;
    sda_oe    = sda_oe_q;
    rx_strobe = rx_strobe_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master plus Avalon access, checked
// against a transaction-level model of the register bank and pointer.
module tb_i2c_target_regs;
  localparam logic [6:0] ADDR7 = 7'h48;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       m_scl, m_sda;
  logic       sda_bus;
  logic       sda_oe, busy, rx_strobe;

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(.I2C_ADDR(ADDR7)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .scl_in    (m_scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .rx_strobe (rx_strobe)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned oe_cycles = 0;
  int unsigned rx_pulses = 0;

  logic [7:0]  bank_m [4];
  int unsigned ptr_m;
  logic [7:0]  dq [$];

  always @(posedge clk) begin
    if (sda_oe)    oe_cycles <= oe_cycles + 1;
    if (rx_strobe) rx_pulses <= rx_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic av_write(input logic [1:0] a, input logic [7:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    wclk(1);
    chipselect = 1'b0; write_n = 1'b1;
    bank_m[a] = d;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [7:0] d);
    address = a; chipselect = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check_bank(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      av_read(i[1:0], d);
      check(tag, d, bank_m[i]);
    end
  endtask

  task automatic i2c_start;
    if (m_scl) begin
      m_sda = 1'b0; wclk(8); m_scl = 1'b0;
    end else begin
      wclk(8); m_sda = 1'b1; wclk(8); m_scl = 1'b1;
      wclk(8); m_sda = 1'b0; wclk(8); m_scl = 1'b0;
    end
  endtask

  task automatic i2c_stop;
    wclk(8); m_sda = 1'b0; wclk(8); m_scl = 1'b1;
    wclk(8); m_sda = 1'b1; wclk(16);
  endtask

  // Collision variant drives an Avalon write to address 1 in the very clock
  // the target acts on the 8th SCL rise (3 clocks after the pin change).
  task automatic write_byte(input logic [7:0] b, input bit collide, output bit acked);
    for (int i = 7; i >= 0; i--) begin
      wclk(8); m_sda = b[i]; wclk(8); m_scl = 1'b1;
      if (collide && i == 0) begin
        wclk(2);
        address = 2'd1; writedata = 8'h55; chipselect = 1'b1; write_n = 1'b0;
        wclk(1);
        chipselect = 1'b0; write_n = 1'b1;
        check("collide_rx_strobe", rx_strobe, 1);
        wclk(13);
      end else begin
        wclk(16);
      end
      m_scl = 1'b0;
    end
    wclk(8); m_sda = 1'b1; wclk(8); m_scl = 1'b1;
    wclk(8); acked = ~sda_bus; wclk(8); m_scl = 1'b0;
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wclk(16); m_scl = 1'b1; wclk(8); b[i] = sda_bus; wclk(8); m_scl = 1'b0;
    end
    wclk(8); m_sda = ack ? 1'b0 : 1'b1; wclk(8); m_scl = 1'b1;
    wclk(8); check("master_ack_slot_oe", sda_oe, 0);
    wclk(8); m_scl = 1'b0; wclk(8); m_sda = 1'b1;
  endtask

  task automatic i2c_write_txn(input logic [6:0] a, input logic [7:0] ptrb,
                               input bit collide, input bit do_stop);
    bit          ack;
    bit          match;
    int unsigned rx0;
    rx0   = rx_pulses;
    match = (a == ADDR7);
    i2c_start;
    write_byte({a, 1'b0}, 1'b0, ack);
    check("wr_addr_ack", ack, match);
    if (!match) begin
      check("nomatch_idle", busy, 0);
      i2c_stop;
      return;
    end
    check("busy_mid", busy, 1);
    write_byte(ptrb, 1'b0, ack);
    check("ptr_ack", ack, 1);
    ptr_m = ptrb % 4;
    for (int k = 0; k < dq.size(); k++) begin
      write_byte(dq[k], collide && (k == dq.size() - 1), ack);
      check("data_ack", ack, 1);
      bank_m[ptr_m] = dq[k];
      if (collide && (k == dq.size() - 1)) bank_m[1] = 8'h55;
      ptr_m = (ptr_m + 1) % 4;
    end
    check("rx_strobe_count", rx_pulses - rx0, dq.size());
    if (do_stop) begin
      i2c_stop;
      check("busy_after_stop", busy, 0);
    end
  endtask

  task automatic i2c_read_txn(input logic [6:0] a, input int n);
    bit         ack;
    bit         match;
    logic [7:0] b;
    match = (a == ADDR7);
    i2c_start;
    write_byte({a, 1'b1}, 1'b0, ack);
    check("rd_addr_ack", ack, match);
    if (!match) begin
      i2c_stop;
      return;
    end
    for (int k = 0; k < n; k++) begin
      read_byte(k < n - 1, b);
      check("rd_data", b, bank_m[ptr_m]);
      if (k < n - 1) ptr_m = (ptr_m + 1) % 4;
    end
    i2c_stop;
    check("busy_after_stop", busy, 0);
  endtask

  function automatic logic [6:0] rand_addr();
    logic [6:0] r;
    r = 7'($urandom);
    return ($urandom_range(0, 3) == 0) ? r : ADDR7;
  endfunction

  initial begin
    int unsigned oe0;
    bit          ack;
    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    for (int i = 0; i < 4; i++) bank_m[i] = '0;
    ptr_m = 0;
    wclk(3);
    check("rst_busy", busy, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_strobe", rx_strobe, 0);
    reset = 1'b0;
    wclk(4);
    check_bank("rst_bank");

    // Write with auto-increment
    dq.delete(); dq.push_back(8'hA5); dq.push_back(8'h3C);
    i2c_write_txn(ADDR7, 8'h02, 1'b0, 1'b1);
    check_bank("autoinc_bank");

    // Address mismatch (0x92 on the wire)
    oe0 = oe_cycles;
    dq.delete();
    i2c_write_txn(7'h49, 8'h00, 1'b0, 1'b1);
    check("nomatch_oe", oe_cycles - oe0, 0);
    check_bank("nomatch_bank");

    // Read with wrap from ptr 3
    av_write(2'd0, 8'h11); av_write(2'd1, 8'h22);
    av_write(2'd2, 8'h33); av_write(2'd3, 8'h44);
    address = 2'd1;
    #1 check("readdata_no_cs", readdata, 0);
    dq.delete();
    i2c_write_txn(ADDR7, 8'h03, 1'b0, 1'b0);
    i2c_read_txn(ADDR7, 3);

    // Pointer upper bits ignored
    dq.delete(); dq.push_back(8'h77);
    i2c_write_txn(ADDR7, 8'hFE, 1'b0, 1'b1);
    check_bank("ptr_mask_bank");

    // Avalon vs I2C collision on bank[1]
    dq.delete(); dq.push_back(8'hAA);
    i2c_write_txn(ADDR7, 8'h01, 1'b1, 1'b1);
    check_bank("collide_bank");

    // Randomized mix
    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 3))
        0: av_write(2'($urandom), 8'($urandom));
        1: begin
          dq.delete();
          for (int k = 0; k < int'($urandom_range(0, 4)); k++) dq.push_back(8'($urandom));
          i2c_write_txn(rand_addr(), 8'($urandom), 1'b0, 1'b1);
        end
        2: i2c_read_txn(rand_addr(), int'($urandom_range(1, 5)));
        default: check_bank("rand_bank");
      endcase
    end
    check_bank("rand_final_bank");

    // Asynchronous reset while the target is driving a read bit low
    for (int i = 0; i < 4; i++) av_write(i[1:0], 8'h3C);
    i2c_start;
    write_byte({ADDR7, 1'b1}, 1'b0, ack);
    check("rstmid_addr_ack", ack, 1);
    wclk(6);
    check("rstmid_oe_before", sda_oe, 1);
    #2 reset = 1'b1;
    #1;
    check("rstmid_oe_after", sda_oe, 0);
    check("rstmid_busy_after", busy, 0);
    m_sda = 1'b1; m_scl = 1'b1;
    wclk(3);
    reset = 1'b0;
    wclk(4);
    for (int i = 0; i < 4; i++) bank_m[i] = '0;
    ptr_m = 0;
    check_bank("rstmid_bank");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (responder) for the far end of the bit-banged I2C bus that the NIOS drives through its SCL/SDA PIOs.
- Watches SCL/SDA and answers its 7-bit address.
- Exposes a 4-byte register bank on both sides:
  - I2C side: register-pointer write, data write and data read, with auto-increment.
  - NIOS side: an Avalon-MM slave, so software can preload and inspect the bytes.
- Drives SDA open-drain only. No clock stretching.

Parameters:
- I2C_ADDR, 7'h48, 7-bit target address compared against the first byte after START.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  Avalon register index 0..3.
- chipselect  input  1  Avalon select.
- write_n  input  1  Avalon write, active low.
- writedata  input  8  Avalon write data.
- readdata  output  8  Avalon read data. Combinational: bank[address] when chipselect=1, else 0.
- scl_in  input  1  raw SCL pin level.
- sda_in  input  1  raw SDA pin level.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- busy  output  1  1 while the FSM is not in IDLE.
- rx_strobe  output  1  one-cycle pulse when an I2C data byte is written into the bank.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all state: bank, ptr, shift register and bit counter;
  - outputs: sda_oe=0, busy=0, rx_strobe=0;
  - synchronizer flops, to 1 (idle bus).
- Input sampling and edge detection:
  - scl_in and sda_in each pass through a 2-flop synchronizer plus one history flop.
  - scl_rise = (prev=0, cur=1); scl_fall = (prev=1, cur=0).
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - Detection latency: 3 clk cycles from the pin change.
- Bit transfer:
  - Bits are shifted in MSB first on scl_rise.
  - The bit counter runs 0..7 and the byte is complete at the 8th scl_rise.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
  - IDLE: START -> ADDR.
  - ADDR: 8 bits received.
    - Upper 7 bits = I2C_ADDR -> ADDR_ACK.
    - Otherwise -> IDLE, with no ACK driven.
  - ADDR_ACK:
    - At the scl_fall after bit 8, assert sda_oe=1; release at the next scl_fall.
    - R/W=0 -> PTR.
    - R/W=1 -> load tx byte = bank[ptr], then RDATA.
  - PTR: 8 bits received; ptr = byte[1:0] (upper bits ignored); ACK as above; -> WDATA.
  - WDATA: 8 bits received; ACK as above; bank[ptr] <= byte, rx_strobe=1 for one cycle; ptr <= ptr+1 mod 4; stays in WDATA.
  - RDATA:
    - Drive each bit at scl_fall: sda_oe = ~bit.
    - The first bit is driven at the scl_fall ending the ACK.
    - After the 8th bit's scl_fall, sda_oe=0 -> RDATA_ACK.
  - RDATA_ACK: sample SDA at scl_rise.
    - Sampled 0 (ACK) -> ptr <= ptr+1 mod 4, load bank[ptr+1], back to RDATA.
    - Sampled 1 (NACK) -> IDLE.
- Global events:
  - START in any state (repeated start) -> ADDR: bit counter cleared, sda_oe=0, ptr kept.
  - STOP in any state -> IDLE, sda_oe=0, ptr kept.
- Pointer wrap: ptr 3 increments to 0 on both write and read paths.
- Simultaneous writes: Avalon write (chipselect & ~write_n) and I2C write to the same bank entry in the same cycle -> Avalon data wins; rx_strobe still pulses.
- Read capture: an Avalon write to bank[ptr] during RDATA does not alter the byte already loaded for transmit.
- busy = (state != IDLE).

Test Plan:
- Reset mid-transfer: assert reset during RDATA with sda_oe=1 -> sda_oe=0 and busy=0 immediately (asynchronous); all bank bytes read 0 via Avalon.
- I2C write with auto-increment:
  - Stimulus: START, 0x90, ptr 0x02, data 0xA5, data 0x3C, STOP.
  - ACK (SDA low) on all 4 bytes; two rx_strobe pulses.
  - Avalon read: bank[2]=0xA5, bank[3]=0x3C; busy returns 0 after STOP.
- Address mismatch: START, 0x92, 8 clocks -> sda_oe never asserts; FSM to IDLE; bank unchanged.
- Read with wrap:
  - Stimulus: Avalon preload bank = {0x11,0x22,0x33,0x44}; I2C write ptr 0x03, repeated START, 0x91, read 3 bytes (ACK, ACK, NACK), STOP.
  - SDA returns 0x44, 0x11, 0x22.
  - sda_oe=0 during each master-ACK slot.
- Pointer upper bits: write ptr 0xFE -> ptr=2; next data byte 0x77 lands in bank[2].
- Collision: Avalon write 0x55 to address 1 in the same clk as the I2C write of 0xAA to bank[1] -> bank[1]=0x55; rx_strobe pulses once.
